fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL take parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL take parameter IMEM_DEPTH, default 256, meaning the number of instruction words addressable; word index = PC[9:2].
REQ-003 SHALL have port clk, input, 1, the single clock, rising-edge.
REQ-004 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port stall_i, input, 1, hazard hold request from decode.
REQ-006 SHALL have port redirect_i, input, 1, taken branch/jump from execute.
REQ-007 SHALL have port redirect_pc_i, input, WIDTH, branch/jump target.
REQ-008 SHALL have port imem_addr_o, output, WIDTH, PC driven to the combinational instruction ROM.
REQ-009 SHALL have port imem_instr_i, input, WIDTH, ROM data, valid in the same cycle as imem_addr_o.
REQ-010 SHALL have port if_id_valid_o, output, 1, IF/ID register holds a real instruction.
REQ-011 SHALL have port if_id_pc_o, output, WIDTH, PC of the IF/ID instruction.
REQ-012 SHALL have port if_id_pc4_o, output, WIDTH, that PC + 4.
REQ-013 SHALL have port if_id_instr_o, output, WIDTH, instruction word.
REQ-014 SHALL have port misalign_o, output, 1, one-cycle pulse on a redirect target with bits [1:0] != 0.

Function
REQ-015 SHALL drive imem_addr_o = pc_q combinationally; fetch-to-IF/ID latency is exactly 1 cycle.
REQ-016 SHALL implement FSM states BOOT, RUN, HALT.
REQ-017 BOOT: first cycle after rst_n rises; no fetch, IF/ID loads bubble, PC holds; unconditionally -> RUN next cycle; stall_i and redirect_i are ignored in BOOT.
REQ-018 Bubble means if_id_valid_o=0, if_id_instr_o=NOP (32'h0000_0013), if_id_pc_o/if_id_pc4_o=0.
REQ-019 RUN, priority redirect > stall > advance.
REQ-020 Redirect (any state except BOOT): pc_q <= {redirect_pc_i[WIDTH-1:2],2'b00}; IF/ID <= bubble (flush); state -> RUN; redirect with stall_i=1 still redirects and flushes.
REQ-021 misalign_o SHALL pulse 1 for the cycle after a redirect whose redirect_pc_i[1:0] != 0; the target is still force-aligned.
REQ-022 Stall (RUN, no redirect): pc_q and all IF/ID outputs hold their values.
REQ-023 Advance (RUN): IF/ID <= {1, pc_q, pc_q+4, imem_instr_i}, and pc_q <= pc_q+4.
REQ-024 PC arithmetic SHALL be modulo 2^WIDTH; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-025 Out-of-range fetch: in RUN with pc_q[WIDTH-1:2] >= IMEM_DEPTH and no redirect, SHALL load a bubble, hold pc_q, and go to HALT.
REQ-026 HALT: PC holds, IF/ID loads a bubble every cycle, stall_i is ignored; only a redirect exits, to RUN.

Reset
REQ-027 On rst_n=0, SHALL asynchronously set pc_q=RESET_PC, state=BOOT, IF/ID=bubble and misalign_o=0.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL discard the pending action; no partial update survives.
REQ-029 Reset SHALL not depend on clk toggling.

Structure
REQ-030 WIDTH, the NOP constant and enum fetch_state_t {BOOT,RUN,HALT} SHALL live in the shared package all_pkgs.
REQ-031 The IF/ID register (valid/pc/pc4/instr, with load, hold and flush controls) SHALL be one sub-module, if_id_reg; PC, next-PC mux and FSM stay in fetch_unit.

Verification
REQ-032 Reset release with RESET_PC=0 and ROM[0..2]=A,B,C -> cycle 1 bubble (BOOT); cycles 2,3,4 show valid pc 0,4,8 with instr A,B,C.
REQ-033 stall_i=1 for 3 cycles while IF/ID holds pc 4 -> outputs frozen at pc 4, imem_addr_o stays 8, and fetch resumes with pc 8.
REQ-034 redirect_i=1, redirect_pc_i=0x40, together with stall_i=1 -> next cycle bubble and imem_addr_o=0x40; the following cycle valid with pc 0x40.
REQ-035 redirect_pc_i=0x42 -> misalign_o=1 for one cycle and the next fetch is at 0x40.
REQ-036 Run to pc 0x400 with IMEM_DEPTH=256 -> HALT, bubbles indefinitely with stall ignored; redirect to 0x10 -> RUN and valid pc 0x10 next.
REQ-037 rst_n pulsed low mid-cycle during advance -> outputs immediately at reset values, then BOOT then RUN from RESET_PC.

Source files
------------

// File: rtl/all_pkgs.sv
// rtl/all_pkgs.sv - shared width, NOP encoding and fetch FSM state type
package all_pkgs;

  localparam int WIDTH = 32;

  // addi x0, x0, 0
  localparam logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, hold and flush-to-bubble
module if_id_reg
  import all_pkgs::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] pc4_i,
  input  logic [WIDTH-1:0] instr_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc4_o,
  output logic [WIDTH-1:0] instr_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc4_q, pc4_d;
  logic [WIDTH-1:0] instr_q, instr_d;

  // Flush wins over load; with neither asserted the register holds.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    if (flush_i) begin
      valid_d = 1'b0;
      pc_d    = '0;
      pc4_d   = '0;
      instr_d = NOP_INSTR;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      pc4_d   = pc4_i;
      instr_d = instr_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      pc4_q   <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register, next-PC selection and BOOT/RUN/HALT fetch FSM
module fetch_unit
  import all_pkgs::*;
#(
  parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int               IMEM_DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic [WIDTH-1:0] imem_instr_i,
  output logic             if_id_valid_o,
  output logic [WIDTH-1:0] if_id_pc_o,
  output logic [WIDTH-1:0] if_id_pc4_o,
  output logic [WIDTH-1:0] if_id_instr_o,
  output logic             misalign_o
);

  localparam logic [WIDTH-3:0] DEPTH_WORDS = (WIDTH-2)'(IMEM_DEPTH);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] redirect_target;
  logic             misalign_q, misalign_d;
  logic             ifid_load;
  logic             ifid_flush;
  logic             out_of_range;

  assign pc_plus4        = pc_q + 32'd4;
  assign redirect_target = {redirect_pc_i[WIDTH-1:2], 2'b00};
  assign out_of_range    = (pc_q[WIDTH-1:2] >= DEPTH_WORDS);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    unique case (state_q)
      BOOT: begin
        ifid_flush = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        if (redirect_i) begin
          pc_d       = redirect_target;
          ifid_flush = 1'b1;
          misalign_d = |redirect_pc_i[1:0];
        end else if (out_of_range) begin
          // Fetching past the ROM parks the front end until a redirect.
          ifid_flush = 1'b1;
          state_d    = HALT;
        end else if (!stall_i) begin
          ifid_load = 1'b1;
          pc_d      = pc_plus4;
        end
      end
      HALT: begin
        ifid_flush = 1'b1;
        if (redirect_i) begin
          pc_d       = redirect_target;
          misalign_d = |redirect_pc_i[1:0];
          state_d    = RUN;
        end
      end
      default: begin
        ifid_flush = 1'b1;
        state_d    = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_addr_o = pc_q;
  assign misalign_o  = misalign_q;

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .pc_i    (pc_q),
    .pc4_i   (pc_plus4),
    .instr_i (imem_instr_i),
    .valid_o (if_id_valid_o),
    .pc_o    (if_id_pc_o),
    .pc4_o   (if_id_pc4_o),
    .instr_o (if_id_instr_o)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc4_o;
  logic [31:0] if_id_instr_o;
  logic        misalign_o;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_DEPTH (256)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_instr_i  (imem_instr_i),
    .if_id_valid_o (if_id_valid_o),
    .if_id_pc_o    (if_id_pc_o),
    .if_id_pc4_o   (if_id_pc4_o),
    .if_id_instr_o (if_id_instr_o),
    .misalign_o    (misalign_o)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    rom_word = 32'hA500_0003 | {14'd0, addr[9:2], 10'd0};
  endfunction

  assign imem_instr_i = rom_word(imem_addr_o);

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic r, input logic [31:0] rpc,
                     input logic v, input logic [31:0] pc, input logic [31:0] addr,
                     input logic mis);
    vec_t t;
    t.stall = s; t.redirect = r; t.rpc = rpc;
    t.exp_valid = v; t.exp_pc = pc; t.exp_addr = addr; t.exp_mis = mis;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] addr, input logic mis);
    logic [31:0] e_pc4;
    logic [31:0] e_instr;
    e_pc4   = v ? pc + 32'd4 : 32'd0;
    e_instr = v ? rom_word(pc) : NOP;
    chk({tag, ".valid"}, {31'd0, if_id_valid_o}, {31'd0, v});
    chk({tag, ".pc"}, if_id_pc_o, v ? pc : 32'd0);
    chk({tag, ".pc4"}, if_id_pc4_o, e_pc4);
    chk({tag, ".instr"}, if_id_instr_o, e_instr);
    chk({tag, ".addr"}, imem_addr_o, addr);
    chk({tag, ".mis"}, {31'd0, misalign_o}, {31'd0, mis});
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] rpc);
    stall_i = s; redirect_i = r; redirect_pc_i = rpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // BOOT ignores stall and redirect
    add(1, 1, 32'h80,  0, 0,     32'h0,   0);
    add(0, 0, 0,       1, 32'h0, 32'h4,   0);
    add(0, 0, 0,       1, 32'h4, 32'h8,   0);
    add(1, 0, 0,       1, 32'h4, 32'h8,   0);
    add(1, 0, 0,       1, 32'h4, 32'h8,   0);
    add(1, 0, 0,       1, 32'h4, 32'h8,   0);
    add(0, 0, 0,       1, 32'h8, 32'hC,   0);
    // redirect beats stall
    add(1, 1, 32'h40,  0, 0,     32'h40,  0);
    add(0, 0, 0,       1, 32'h40, 32'h44, 0);
    add(0, 1, 32'h42,  0, 0,     32'h40,  1);
    add(0, 0, 0,       1, 32'h40, 32'h44, 0);
    // walk off the end of a 256-word ROM
    add(0, 1, 32'h3F8, 0, 0,     32'h3F8, 0);
    add(0, 0, 0,       1, 32'h3F8, 32'h3FC, 0);
    add(0, 0, 0,       1, 32'h3FC, 32'h400, 0);
    add(0, 0, 0,       0, 0,     32'h400, 0);
    add(1, 0, 0,       0, 0,     32'h400, 0);
    add(0, 0, 0,       0, 0,     32'h400, 0);
    add(0, 1, 32'h11,  0, 0,     32'h10,  1);
    add(0, 0, 0,       1, 32'h10, 32'h14, 0);
    add(0, 0, 0,       1, 32'h14, 32'h18, 0);

    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 0, 0, 32'h0, 0);

    rst_n = 1'b1;
    foreach (vecs[i]) begin
      step(vecs[i].stall, vecs[i].redirect, vecs[i].rpc);
      chk_state($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                vecs[i].exp_addr, vecs[i].exp_mis);
    end

    // asynchronous reset mid-cycle during advance
    step(0, 0, 0);
    chk_state("pre_rst", 1, 32'h18, 32'h1C, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", 0, 0, 32'h0, 0);
    rst_n = 1'b1;
    step(0, 0, 0);
    chk_state("rst_boot", 0, 0, 32'h0, 0);
    step(0, 0, 0);
    chk_state("rst_run", 1, 32'h0, 32'h4, 0);

    // reset during a misaligned redirect pulse, with a redirect still requested
    step(0, 1, 32'h42);
    chk_state("mis_pulse", 0, 0, 32'h40, 1);
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h83;
    #3;
    rst_n = 1'b0;
    #1;
    chk_state("rst_mid_redir", 0, 0, 32'h0, 0);
    @(posedge clk);
    #1;
    chk_state("rst_held", 0, 0, 32'h0, 0);
    rst_n = 1'b1;
    step(1, 1, 32'h83);
    chk_state("rst2_boot", 0, 0, 32'h0, 0);
    step(0, 0, 0);
    chk_state("rst2_run", 1, 32'h0, 32'h4, 0);
    step(0, 0, 0);
    chk_state("rst2_run2", 1, 32'h4, 32'h8, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
